// File: rtl/lockstep_pkg.sv
// Shared types and constants for the lockstep mode controller.
package lockstep_pkg;

  typedef enum logic [1:0] {
    StRun,
    StBlock,
    StDrain,
    StSwitch
  } lockstep_ctrl_state_e;

  localparam int unsigned LS_NB_CORES = 8;
  localparam int unsigned LS_TIMEOUT  = 1024;

  localparam logic LS_MODE_INDEP    = 1'b0;
  localparam logic LS_MODE_LOCKSTEP = 1'b1;

endpackage

// File: rtl/lockstep_outstanding_cnt.sv
// Per-port outstanding-transaction counter; saturates at both ends and flags the attempt.
module lockstep_outstanding_cnt #(
  parameter int unsigned Width = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic zero_o,
  output logic ovf_o,
  output logic udf_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count; simultaneous inc and dec cancel out.
  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    udf_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (&cnt_q) ovf_o = 1'b1;
      else        cnt_d = cnt_q + Width'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) udf_o = 1'b1;
      else             cnt_d = cnt_q - Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lockstep_mode_ctrl.sv
// Sequences lockstep mode entry/exit: block new requests, drain, switch, release.
// Also watches the core request vector for divergence while in lockstep.
module lockstep_mode_ctrl
  import lockstep_pkg::*;
#(
  parameter int unsigned NB_CORES = LS_NB_CORES,
  parameter int unsigned OUT_W    = 2,
  parameter int unsigned TIMEOUT  = LS_TIMEOUT,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                mode_req_valid_i,
  input  logic                mode_req_i,
  output logic                mode_ack_o,
  output logic                mode_err_o,
  output logic                busy_o,
  output logic                lockstep_mode_o,
  output logic                block_o,
  input  logic [NB_CORES-1:0] core_req_i,
  input  logic [NB_CORES-1:0] ic_gnt_i,
  input  logic [NB_CORES-1:0] ic_rvalid_i,
  output logic                mismatch_o,
  output logic [ERRCNT_W-1:0] mismatch_cnt_o,
  output logic                protocol_err_o,
  input  logic                clr_err_i
);

  localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lockstep_ctrl_state_e state_q;
  logic                 mode_q, target_q, block_q, ack_q, err_q;
  logic [TmrW-1:0]      tmr_q;

  logic [NB_CORES-1:0] cnt_zero, cnt_ovf, cnt_udf;

  for (genvar p = 0; p < NB_CORES; p++) begin : g_cnt
    lockstep_outstanding_cnt #(
      .Width (OUT_W)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (core_req_i[p] & ic_gnt_i[p]),
      .dec_i  (ic_rvalid_i[p]),
      .zero_o (cnt_zero[p]),
      .ovf_o  (cnt_ovf[p]),
      .udf_o  (cnt_udf[p])
    );
  end

  // Mode-change sequencer; the mode flips on the DRAIN->SWITCH edge together with the ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StRun;
      mode_q   <= LS_MODE_INDEP;
      target_q <= LS_MODE_INDEP;
      block_q  <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      tmr_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (mode_req_valid_i) begin
            if (mode_req_i == mode_q) begin
              ack_q <= 1'b1;
            end else begin
              target_q <= mode_req_i;
              block_q  <= 1'b1;
              state_q  <= StBlock;
            end
          end
        end
        // One settling cycle so a grant in the request cycle reaches the counters.
        StBlock: begin
          tmr_q   <= '0;
          state_q <= StDrain;
        end
        StDrain: begin
          if (&cnt_zero) begin
            mode_q  <= target_q;
            ack_q   <= 1'b1;
            state_q <= StSwitch;
          end else if (tmr_q == TmrW'(TIMEOUT - 1)) begin
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            block_q <= 1'b0;
            state_q <= StRun;
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
        StSwitch: begin
          block_q <= 1'b0;
          state_q <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

  logic                mm_hit;
  logic                mm_q, mm_d, perr_q, perr_d;
  logic [ERRCNT_W-1:0] mm_cnt_q, mm_cnt_d;

  // Divergence: cores disagree when the request vector is neither all-zero nor all-ones.
  assign mm_hit = (state_q == StRun) && (mode_q == LS_MODE_LOCKSTEP) && !block_q &&
                  (|core_req_i) && !(&core_req_i);

  // Error next-state: clear first so a same-cycle new error still lands.
  always_comb begin
    mm_d     = mm_q;
    mm_cnt_d = mm_cnt_q;
    perr_d   = perr_q;
    if (clr_err_i) begin
      mm_d     = 1'b0;
      mm_cnt_d = '0;
      perr_d   = 1'b0;
    end
    if (mm_hit) begin
      mm_d = 1'b1;
      if (!(&mm_cnt_d)) mm_cnt_d = mm_cnt_d + ERRCNT_W'(1);
    end
    if ((|cnt_ovf) || (|cnt_udf)) perr_d = 1'b1;
  end

  // Sticky error registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mm_q     <= 1'b0;
      mm_cnt_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      mm_q     <= mm_d;
      mm_cnt_q <= mm_cnt_d;
      perr_q   <= perr_d;
    end
  end

  assign mode_ack_o      = ack_q;
  assign mode_err_o      = err_q;
  assign busy_o          = (state_q != StRun);
  assign lockstep_mode_o = mode_q;
  assign block_o         = block_q;
  assign mismatch_o      = mm_q;
  assign mismatch_cnt_o  = mm_cnt_q;
  assign protocol_err_o  = perr_q;

endmodule

// File: tb/tb_lockstep_mode_ctrl.sv
// Scoreboard bench for lockstep_mode_ctrl with a timeline-level reference model.
module tb_lockstep_mode_ctrl;

  localparam int unsigned NC = 8;
  localparam int unsigned OW = 2;
  localparam int unsigned TO = 16;
  localparam int unsigned EW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mode_req_valid = 1'b0, mode_req = 1'b0, clr_err = 1'b0;
  logic [NC-1:0] core_req = '0, ic_gnt = '0, ic_rvalid = '0;
  logic          mode_ack, mode_err, busy, lockstep_mode, block, mismatch, protocol_err;
  logic [EW-1:0] mismatch_cnt;

  always #5 clk = ~clk;

  lockstep_mode_ctrl #(
    .NB_CORES (NC),
    .OUT_W    (OW),
    .TIMEOUT  (TO),
    .ERRCNT_W (EW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .mode_req_valid_i (mode_req_valid),
    .mode_req_i       (mode_req),
    .mode_ack_o       (mode_ack),
    .mode_err_o       (mode_err),
    .busy_o           (busy),
    .lockstep_mode_o  (lockstep_mode),
    .block_o          (block),
    .core_req_i       (core_req),
    .ic_gnt_i         (ic_gnt),
    .ic_rvalid_i      (ic_rvalid),
    .mismatch_o       (mismatch),
    .mismatch_cnt_o   (mismatch_cnt),
    .protocol_err_o   (protocol_err),
    .clr_err_i        (clr_err)
  );

  typedef struct {
    int cyc;
    bit err;
    bit mode;
  } ack_t;

  ack_t sb_q[$];
  int   n_chk = 0, n_pass = 0, cyc = 0;

  // Reference model: a pending transaction is described by its request cycle and end cycle.
  int m_cnt[NC];
  bit m_mode, m_perr, m_mm, m_in_xact, m_target;
  int m_mmcnt, m_r, m_end;
  bit e_busy;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit m_busy(input int x);
    return m_in_xact && (x > m_r) && (m_end < 0 || x <= m_end);
  endfunction

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_mode = 0; m_perr = 0; m_mm = 0; m_mmcnt = 0;
    m_in_xact = 0; m_r = 0; m_end = -1; m_target = 0; e_busy = 0;
    sb_q.delete();
  endtask

  // Consumes the inputs of cycle p-1 and produces the expectations for cycle p.
  task automatic model_step(input int p);
    int q;
    bit mixed, allz, inc, dec;
    q = p - 1;
    mixed = (core_req != '0) && (core_req != '1);
    if (clr_err) begin
      m_mm = 0; m_mmcnt = 0; m_perr = 0;
    end
    if (!m_busy(q) && m_mode && mixed) begin
      m_mm = 1;
      if (m_mmcnt < (2 ** EW) - 1) m_mmcnt++;
    end
    if (m_in_xact && m_end >= 0 && q > m_end) m_in_xact = 0;
    if (!m_in_xact) begin
      if (mode_req_valid) begin
        if (mode_req == m_mode) sb_q.push_back('{p, 1'b0, m_mode});
        else begin
          m_in_xact = 1; m_r = q; m_end = -1; m_target = mode_req;
        end
      end
    end else if (m_end < 0 && q >= m_r + 2) begin
      allz = 1;
      foreach (m_cnt[i]) if (m_cnt[i] != 0) allz = 0;
      if (allz) begin
        m_mode = m_target;
        sb_q.push_back('{p, 1'b0, m_mode});
        m_end = p;
      end else if (q - (m_r + 2) == int'(TO) - 1) begin
        sb_q.push_back('{p, 1'b1, m_mode});
        m_end = q;
      end
    end
    for (int i = 0; i < int'(NC); i++) begin
      inc = core_req[i] & ic_gnt[i];
      dec = ic_rvalid[i];
      if (inc && !dec) begin
        if (m_cnt[i] == (2 ** OW) - 1) m_perr = 1;
        else m_cnt[i]++;
      end else if (dec && !inc) begin
        if (m_cnt[i] == 0) m_perr = 1;
        else m_cnt[i]--;
      end
    end
    e_busy = m_busy(p);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) model_reset();
      else model_step(cyc);
    end
  end

  // Monitor: pops an expected ack whenever the DUT acks, and checks status every cycle.
  initial begin
    ack_t a;
    forever begin
      @(negedge clk);
      if (mode_ack) begin
        if (sb_q.size() == 0) check("unexpected_ack", mode_ack, 0);
        else begin
          a = sb_q.pop_front();
          check("ack_cycle", cyc, a.cyc);
          check("ack_err", mode_err, a.err);
          check("ack_mode", lockstep_mode, a.mode);
        end
      end else begin
        check("err_without_ack", mode_err, 0);
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
          check("ack_missing", mode_ack, 1);
          void'(sb_q.pop_front());
        end
      end
      check("busy", busy, e_busy);
      check("block", block, e_busy);
      check("lockstep_mode", lockstep_mode, m_mode);
      check("mismatch", mismatch, m_mm);
      check("mismatch_cnt", mismatch_cnt, m_mmcnt);
      check("protocol_err", protocol_err, m_perr);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mode_req_valid = 0; clr_err = 0;
      core_req = '0; ic_gnt = '0; ic_rvalid = '0;
    end
  endtask

  task automatic request(input bit m);
    @(negedge clk);
    mode_req_valid = 1; mode_req = m;
    core_req = '0; ic_gnt = '0; ic_rvalid = '0; clr_err = 0;
  endtask

  task automatic grant(input int p);
    @(negedge clk);
    mode_req_valid = 0; ic_rvalid = '0;
    core_req = '0; ic_gnt = '0;
    core_req[p] = 1; ic_gnt[p] = 1;
  endtask

  task automatic rvalid(input int p);
    @(negedge clk);
    mode_req_valid = 0; core_req = '0; ic_gnt = '0;
    ic_rvalid = '0; ic_rvalid[p] = 1;
  endtask

  initial begin
    int r;
    idle(3);
    rst_n = 1;
    idle(5);

    // Idle cluster entry into lockstep: ack three cycles after the request.
    request(1);
    idle(2);
    check("t1_block_in_drain", block, 1);
    idle(1);
    check("t1_ack_latency", mode_ack, 1);
    check("t1_mode_switched", lockstep_mode, 1);
    idle(1);
    check("t1_busy_released", busy, 0);
    idle(3);

    // Divergence monitor.
    @(negedge clk); core_req = '1; clr_err = 1;
    @(negedge clk); core_req = 8'hFE; clr_err = 0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); core_req = '0;
    check("t4_mismatch", mismatch, 1);
    check("t4_mismatch_cnt", mismatch_cnt, 3);
    clr_err = 1;
    @(negedge clk); clr_err = 0;
    check("t4_cleared_cnt", mismatch_cnt, 0);
    check("t4_cleared_flag", mismatch, 0);

    // Exit lockstep while port 3 is outstanding.
    grant(3);
    request(0);
    idle(13);
    check("t2_still_draining", busy, 1);
    rvalid(3);
    idle(2);
    check("t2_mode_toggled", lockstep_mode, 0);
    idle(4);

    // Drain timeout: port 0 never returns.
    grant(0);
    request(1);
    idle(int'(TO) + 6);
    check("t3_mode_unchanged", lockstep_mode, 0);
    check("t3_block_low", block, 0);
    rvalid(0);
    idle(2);

    // Protocol errors and same-cycle gnt/r_valid.
    rvalid(2);
    idle(1);
    check("t5_underflow", protocol_err, 1);
    clr_err = 1;
    grant(5);
    clr_err = 0;
    @(negedge clk);
    core_req = '0; ic_gnt = '0; ic_rvalid = '0;
    core_req[5] = 1; ic_gnt[5] = 1; ic_rvalid[5] = 1;
    request(1);
    idle(5);
    check("t5_count_held", busy, 1);
    rvalid(5);
    idle(5);

    // Asynchronous reset in the middle of a drain.
    grant(1);
    request(0);
    idle(4);
    #2 rst_n = 0;
    model_reset();
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_block", block, 0);
    check("t6_rst_mode", lockstep_mode, 0);
    check("t6_rst_ack", mode_ack, 0);
    idle(2);
    rst_n = 1;
    idle(2);
    request(0);
    idle(1);
    check("t6_same_mode_ack", mode_ack, 1);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 9);
      core_req = (r < 4) ? '0 : (r < 8) ? '1 : NC'($urandom);
      ic_gnt = NC'($urandom) & NC'($urandom);
      ic_rvalid = '0;
      for (int k = 0; k < int'(NC); k++)
        if (m_cnt[k] > 0 && $urandom_range(0, 2) == 0) ic_rvalid[k] = 1;
      if ($urandom_range(0, 199) == 0) ic_rvalid[$urandom_range(0, NC - 1)] = 1;
      mode_req_valid = ($urandom_range(0, 29) == 0);
      mode_req = 1'($urandom_range(0, 1));
      clr_err = ($urandom_range(0, 59) == 0);
    end
    idle(int'(TO) + 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lockstep_mode_ctrl.md
Name: lockstep_mode_ctrl

Overview:
Sequences safe entry into and exit from cluster lockstep mode for the NB_CORES core-side TCDM ports. On a software mode-change request it blocks new core requests, drains outstanding transactions, switches the registered lockstep_mode_o in a single clock edge, then releases the ports. In lockstep mode it also monitors the core request vector for divergence. It sits beside the lockstep bus wrapper and drives that wrapper's lockstep_mode input plus a per-port request-blocking gate.

Parameters:
NB_CORES, 8, number of core-side TCDM ports observed
OUT_W, 2, width of each per-port outstanding-transaction counter
TIMEOUT, 1024, maximum drain cycles before abort
ERRCNT_W, 8, width of the saturating mismatch counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
mode_req_valid_i  in  1  mode-change request strobe, single cycle
mode_req_i  in  1  requested mode (1 = lockstep)
mode_ack_o  out  1  one-cycle pulse: request completed
mode_err_o  out  1  qualifies mode_ack_o: drain timed out, mode unchanged
busy_o  out  1  FSM not in RUN
lockstep_mode_o  out  1  registered mode fed to the bus wrapper
block_o  out  1  wrapper must not forward new core req or return gnt
core_req_i  in  NB_CORES  core-side req
ic_gnt_i  in  NB_CORES  interconnect-side gnt
ic_rvalid_i  in  NB_CORES  interconnect-side r_valid
mismatch_o  out  1  sticky divergence flag
mismatch_cnt_o  out  ERRCNT_W  saturating divergence count
protocol_err_o  out  1  sticky: r_valid seen with counter at 0, or counter overflow
clr_err_i  in  1  clears mismatch_o, mismatch_cnt_o and protocol_err_o

Behaviour:
- Reset values: all outputs 0, FSM in RUN, all counters 0, lockstep_mode_o = 0 (independent mode).
- Outstanding counter per port p:
  - increments on core_req_i[p] & ic_gnt_i[p];
  - decrements on ic_rvalid_i[p];
  - holds when both occur in the same cycle.
  - Decrement at 0: hold at 0 and set protocol_err_o.
  - Increment at all-ones: hold and set protocol_err_o.
- FSM states: RUN, BLOCK, DRAIN, SWITCH.
- RUN:
  - If mode_req_valid_i and mode_req_i == lockstep_mode_o: mode_ack_o pulses next cycle, no state change.
  - If mode_req_valid_i and mode_req_i differs: latch target, go to BLOCK.
  - mode_req_valid_i in any state other than RUN is ignored; software polls busy_o.
- BLOCK:
  - block_o = 1, registered and asserted from this state onward.
  - Exists so that a grant coinciding with the request cycle is counted.
  - Next state is DRAIN.
- DRAIN:
  - block_o = 1; timeout counter increments each cycle.
  - All outstanding counters 0: go to SWITCH. This takes priority if it coincides with the timeout count.
  - Timeout counter reaches TIMEOUT-1: go to RUN, mode unchanged, mode_ack_o = mode_err_o = 1 for one cycle, block_o deasserts.
- SWITCH:
  - lockstep_mode_o <= target; block_o stays 1 during this cycle.
  - Next state is RUN with mode_ack_o pulsed; block_o drops on entry to RUN.
  - Total latency with nothing outstanding: request cycle + 3 cycles to ack.
- Mismatch monitor, active only in RUN with lockstep_mode_o = 1 and block_o = 0:
  - core_req_i neither all-zero nor all-ones sets mismatch_o.
  - Each such cycle increments mismatch_cnt_o, saturating at all-ones.
- clr_err_i priority: clr_err_i in the same cycle as a new error clears first, then the new error sets, so the flag ends 1 and the count ends 1.
- Reset mid-drain: immediate return to RUN, mode 0, block_o 0. Any pending ack is lost.

Decomposition:
- Package lockstep_pkg holds:
  - the FSM state enum lockstep_ctrl_state_e;
  - the default constants for NB_CORES and TIMEOUT;
  - the mode encoding constants LS_MODE_INDEP = 0 and LS_MODE_LOCKSTEP = 1.
- One sub-module, lockstep_outstanding_cnt: a single up/down counter with overflow and underflow flags, instantiated NB_CORES times by generate.

Test Plan:
1. Idle cluster; request mode 1 at cycle 10 -> block_o high cycles 11–13, lockstep_mode_o = 1 from cycle 13, mode_ack_o at cycle 13, mode_err_o = 0, busy_o low from cycle 14.
2. Port 3 granted at cycle 5, r_valid at cycle 20, mode request at cycle 6 -> state stays DRAIN until the counter reaches 0; lockstep_mode_o toggles at cycle 22.
3. TIMEOUT = 16, port 0 granted and r_valid never returned -> mode_ack_o with mode_err_o = 1 after 16 DRAIN cycles; lockstep_mode_o unchanged; block_o low afterwards.
4. Lockstep mode, core_req_i = 0xFF then 0xFE for 3 cycles -> mismatch_o = 1, mismatch_cnt_o = 3. clr_err_i -> both 0.
5. ic_rvalid_i[2] with counter 0 -> protocol_err_o = 1, counter stays 0. Same-cycle gnt and r_valid on a port with counter 1 -> counter stays 1.
6. rst_ni asserted during DRAIN -> all outputs 0 asynchronously; after release, a request for mode 0 acks in 1 cycle with no mode change.
